// File: rtl/ysyx_22050612_lsu_pkg.sv
// Shared LSU definitions: FSM states, access-size codes, request metadata and lane helpers.
// Pure declarations and functions; no latency, no flow control.
package ysyx_22050612_lsu_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_WAIT = 2'd2,
    S_DONE = 2'd3
  } lsu_state_t;

  localparam logic [1:0] SZ_B = 2'd0;
  localparam logic [1:0] SZ_H = 2'd1;
  localparam logic [1:0] SZ_W = 2'd2;
  localparam logic [1:0] SZ_D = 2'd3;

  typedef struct packed {
    logic       store;
    logic [1:0] size;
    logic       uns;
  } req_meta_t;

  function automatic logic [4:0] size_bytes(input logic [1:0] size);
    return 5'd1 << size;
  endfunction

  // Byte-lane enables over two lines so a crossing access shows its high-line lanes too.
  function automatic logic [15:0] lane_mask(input logic [1:0] size, input logic [2:0] off);
    logic [15:0] base;
    case (size)
      SZ_B:    base = 16'h0001;
      SZ_H:    base = 16'h0003;
      SZ_W:    base = 16'h000f;
      default: base = 16'h00ff;
    endcase
    return base << off;
  endfunction

  function automatic logic [6:0] lane_shift(input logic [2:0] off);
    return {1'b0, off, 3'b000};
  endfunction

  function automatic logic [63:0] size_keep(input logic [1:0] size);
    case (size)
      SZ_B:    return 64'h0000_0000_0000_00ff;
      SZ_H:    return 64'h0000_0000_0000_ffff;
      SZ_W:    return 64'h0000_0000_ffff_ffff;
      default: return 64'hffff_ffff_ffff_ffff;
    endcase
  endfunction

endpackage

// File: rtl/ysyx_22050612_lsu_if.sv
// LSU bus bundle: request-in, memory request/response and result handshakes.
// master = LSU side, slave = pipeline/memory environment side.
interface ysyx_22050612_lsu_if #(
  parameter int XLEN  = 64,
  parameter int NBYTE = XLEN / 8
);
  logic             in_valid;
  logic             in_ready;
  logic             in_store;
  logic [1:0]       in_size;
  logic             in_unsigned;
  logic [XLEN-1:0]  in_addr;
  logic [XLEN-1:0]  in_wdata;
  logic [4:0]       in_rd;

  logic             mem_req_valid;
  logic             mem_req_ready;
  logic             mem_req_we;
  logic [XLEN-1:0]  mem_req_addr;
  logic [XLEN-1:0]  mem_req_wdata;
  logic [NBYTE-1:0] mem_req_wmask;
  logic             mem_rsp_valid;
  logic [XLEN-1:0]  mem_rsp_rdata;

  logic             out_valid;
  logic             out_ready;
  logic [XLEN-1:0]  out_rdata;
  logic [4:0]       out_rd;
  logic             out_fault;

  modport master (
    input  in_valid, in_store, in_size, in_unsigned, in_addr, in_wdata, in_rd,
    output in_ready,
    output mem_req_valid, mem_req_we, mem_req_addr, mem_req_wdata, mem_req_wmask,
    input  mem_req_ready, mem_rsp_valid, mem_rsp_rdata,
    output out_valid, out_rdata, out_rd, out_fault,
    input  out_ready
  );

  modport slave (
    output in_valid, in_store, in_size, in_unsigned, in_addr, in_wdata, in_rd,
    input  in_ready,
    input  mem_req_valid, mem_req_we, mem_req_addr, mem_req_wdata, mem_req_wmask,
    output mem_req_ready, mem_rsp_valid, mem_rsp_rdata,
    input  out_valid, out_rdata, out_rd, out_fault,
    output out_ready
  );
endinterface

// File: rtl/ysyx_22050612_lsu_ext.sv
// Load lane extract plus sign/zero extension from a (possibly two-line) response window.
// Purely combinational; no flow control.
module ysyx_22050612_lsu_ext
  import ysyx_22050612_lsu_pkg::*;
#(
  parameter int XLEN = 64,
  parameter int OW   = 3
) (
  input  logic [2*XLEN-1:0] data,
  input  logic [OW-1:0]     off,
  input  logic [1:0]        size,
  input  logic              uns,
  output logic [XLEN-1:0]   res
);
  logic [XLEN-1:0] sh;
  logic [63:0]     keep64;
  logic [XLEN-1:0] keep;
  logic            sbit;

  always_comb begin
    sh     = XLEN'(data >> lane_shift(3'(off)));
    keep64 = size_keep(size);
    keep   = keep64[XLEN-1:0];
    case (size)
      SZ_B:    sbit = sh[7];
      SZ_H:    sbit = sh[15];
      default: sbit = sh[31];
    endcase
    // Full-width accesses have keep all ones, so the sign fill vanishes.
    res = (sh & keep) | ((sbit & ~uns) ? ~keep : '0);
  end

endmodule

// File: rtl/ysyx_22050612_lsu.sv
// Load/store unit: IDLE->REQ->WAIT->DONE, 3-cycle min latency (1 on fault); holds REQ/DONE under back-pressure.
// YSYX_22050612_LSU_MISALIGN_SPLIT_EN: split line-crossing accesses into two memory transactions instead of faulting.
module ysyx_22050612_lsu
  import ysyx_22050612_lsu_pkg::*;
#(
  parameter int XLEN = 64,
  localparam int NBYTE = XLEN / 8
) (
  input logic                 clk,
  input logic                 rst,
  ysyx_22050612_lsu_if.master bus
);
  localparam int LOW = $clog2(NBYTE);
  localparam int MW  = 2 * NBYTE;

  lsu_state_t       state;
  req_meta_t        meta_q;
  logic [LOW-1:0]   off_q;
  logic             in_ready_q;
  logic             mem_req_valid_q;
  logic             mem_req_we_q;
  logic [XLEN-1:0]  mem_req_addr_q;
  logic [XLEN-1:0]  mem_req_wdata_q;
  logic [NBYTE-1:0] mem_req_wmask_q;
  logic             out_valid_q;
  logic [XLEN-1:0]  out_rdata_q;
  logic [4:0]       out_rd_q;
  logic             out_fault_q;

  logic [LOW-1:0]   in_off;
  logic [63:0]      keep64;
  logic [XLEN-1:0]  wdata_kept;
  logic             bad_size;
  logic             misaligned;
  logic             illegal;
  logic [2*XLEN-1:0] ext_data;
  logic [XLEN-1:0]  ext_res;

`ifdef YSYX_22050612_LSU_MISALIGN_SPLIT_EN
  logic [2*XLEN-1:0] wide_wdata;
  logic [MW-1:0]     wide_wmask;
  logic [4:0]        span;
  logic              crosses;
  logic [XLEN-1:0]   hi_wdata_q;
  logic [NBYTE-1:0]  hi_wmask_q;
  logic [XLEN-1:0]   lo_q;
  logic              split_q;
  logic              second_q;
`else
  logic [XLEN-1:0]   lane_wdata;
  logic [NBYTE-1:0]  lane_wmask;
`endif

  always_comb begin
    in_off     = bus.in_addr[LOW-1:0];
    keep64     = size_keep(bus.in_size);
    wdata_kept = bus.in_wdata & keep64[XLEN-1:0];
    bad_size   = (XLEN == 32) && (bus.in_size == SZ_D);
    case (bus.in_size)
      SZ_B:    misaligned = 1'b0;
      SZ_H:    misaligned = bus.in_addr[0];
      SZ_W:    misaligned = |bus.in_addr[1:0];
      default: misaligned = |bus.in_addr[2:0];
    endcase
`ifdef YSYX_22050612_LSU_MISALIGN_SPLIT_EN
    wide_wdata = {{XLEN{1'b0}}, wdata_kept} << lane_shift(3'(in_off));
    wide_wmask = MW'(lane_mask(bus.in_size, 3'(in_off)));
    span       = 5'(in_off) + size_bytes(bus.in_size);
    crosses    = misaligned && (span > 5'(NBYTE));
    illegal    = bad_size;
`else
    lane_wdata = wdata_kept << lane_shift(3'(in_off));
    lane_wmask = NBYTE'(lane_mask(bus.in_size, 3'(in_off)));
    illegal    = bad_size | misaligned;
`endif
  end

`ifdef YSYX_22050612_LSU_MISALIGN_SPLIT_EN
  assign ext_data = second_q ? {bus.mem_rsp_rdata, lo_q} : {{XLEN{1'b0}}, bus.mem_rsp_rdata};
`else
  assign ext_data = {{XLEN{1'b0}}, bus.mem_rsp_rdata};
`endif

  ysyx_22050612_lsu_ext #(
    .XLEN (XLEN),
    .OW   (LOW)
  ) u_ext (
    .data (ext_data),
    .off  (off_q),
    .size (meta_q.size),
    .uns  (meta_q.uns),
    .res  (ext_res)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state           <= S_IDLE;
      meta_q          <= '0;
      off_q           <= '0;
      in_ready_q      <= 1'b1;
      mem_req_valid_q <= 1'b0;
      mem_req_we_q    <= 1'b0;
      mem_req_addr_q  <= '0;
      mem_req_wdata_q <= '0;
      mem_req_wmask_q <= '0;
      out_valid_q     <= 1'b0;
      out_rdata_q     <= '0;
      out_rd_q        <= '0;
      out_fault_q     <= 1'b0;
`ifdef YSYX_22050612_LSU_MISALIGN_SPLIT_EN
      hi_wdata_q      <= '0;
      hi_wmask_q      <= '0;
      lo_q            <= '0;
      split_q         <= 1'b0;
      second_q        <= 1'b0;
`endif
    end else begin
      case (state)
        S_IDLE: begin
          if (bus.in_valid) begin
            meta_q      <= '{store: bus.in_store, size: bus.in_size, uns: bus.in_unsigned};
            off_q       <= in_off;
            in_ready_q  <= 1'b0;
            out_rd_q    <= bus.in_rd;
            out_rdata_q <= '0;
            if (illegal) begin
              state       <= S_DONE;
              out_fault_q <= 1'b1;
              out_valid_q <= 1'b1;
            end else begin
              state           <= S_REQ;
              out_fault_q     <= 1'b0;
              mem_req_valid_q <= 1'b1;
              mem_req_we_q    <= bus.in_store;
              mem_req_addr_q  <= {bus.in_addr[XLEN-1:LOW], {LOW{1'b0}}};
`ifdef YSYX_22050612_LSU_MISALIGN_SPLIT_EN
              mem_req_wdata_q <= bus.in_store ? wide_wdata[XLEN-1:0] : '0;
              mem_req_wmask_q <= bus.in_store ? wide_wmask[NBYTE-1:0] : '0;
              hi_wdata_q      <= bus.in_store ? wide_wdata[2*XLEN-1:XLEN] : '0;
              hi_wmask_q      <= bus.in_store ? wide_wmask[MW-1:NBYTE] : '0;
              split_q         <= crosses;
              second_q        <= 1'b0;
`else
              mem_req_wdata_q <= bus.in_store ? lane_wdata : '0;
              mem_req_wmask_q <= bus.in_store ? lane_wmask : '0;
`endif
            end
          end
        end
        S_REQ: begin
          if (bus.mem_req_ready) begin
            state           <= S_WAIT;
            mem_req_valid_q <= 1'b0;
          end
        end
        S_WAIT: begin
          if (bus.mem_rsp_valid) begin
`ifdef YSYX_22050612_LSU_MISALIGN_SPLIT_EN
            // First half of a crossing access: park the low line and go fetch the next one.
            if (split_q && !second_q) begin
              second_q        <= 1'b1;
              lo_q            <= bus.mem_rsp_rdata;
              state           <= S_REQ;
              mem_req_valid_q <= 1'b1;
              mem_req_addr_q  <= mem_req_addr_q + XLEN'(NBYTE);
              mem_req_wdata_q <= hi_wdata_q;
              mem_req_wmask_q <= hi_wmask_q;
            end else begin
`else
            begin
`endif
              state       <= S_DONE;
              out_valid_q <= 1'b1;
              out_rdata_q <= meta_q.store ? '0 : ext_res;
            end
          end
        end
        S_DONE: begin
          if (bus.out_ready) begin
            state       <= S_IDLE;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign bus.in_ready      = in_ready_q;
  assign bus.mem_req_valid = mem_req_valid_q;
  assign bus.mem_req_we    = mem_req_we_q;
  assign bus.mem_req_addr  = mem_req_addr_q;
  assign bus.mem_req_wdata = mem_req_wdata_q;
  assign bus.mem_req_wmask = mem_req_wmask_q;
  assign bus.out_valid     = out_valid_q;
  assign bus.out_rdata     = out_rdata_q;
  assign bus.out_rd        = out_rd_q;
  assign bus.out_fault     = out_fault_q;

endmodule

// File: tb/tb_ysyx_22050612_lsu.sv
// Directed bench for ysyx_22050612_lsu at XLEN=64: latency, lane placement, extension, faults, back-pressure, reset abort.
module tb_ysyx_22050612_lsu;
  import ysyx_22050612_lsu_pkg::*;

  logic clk = 1'b0;
  logic rst;
  int   tests   = 0;
  int   fails   = 0;
  int   req_cnt = 0;
  int   out_cnt = 0;
  int   r0, o0;

  ysyx_22050612_lsu_if #(.XLEN(64)) bus ();
  ysyx_22050612_lsu #(.XLEN(64)) dut (.clk(clk), .rst(rst), .bus(bus));

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (bus.mem_req_valid && bus.mem_req_ready) req_cnt++;
    if (bus.out_valid && bus.out_ready) out_cnt++;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic issue(input logic st, input logic [1:0] sz, input logic uns,
                       input logic [63:0] addr, input logic [63:0] wd, input logic [4:0] rd);
    bus.in_valid    = 1'b1;
    bus.in_store    = st;
    bus.in_size     = sz;
    bus.in_unsigned = uns;
    bus.in_addr     = addr;
    bus.in_wdata    = wd;
    bus.in_rd       = rd;
    step();
    bus.in_valid    = 1'b0;
  endtask

  task automatic respond(input logic [63:0] rdata);
    bus.mem_rsp_valid = 1'b1;
    bus.mem_rsp_rdata = rdata;
    step();
    bus.mem_rsp_valid = 1'b0;
  endtask

  task automatic load_check(input string tag, input logic [1:0] sz, input logic uns,
                            input logic [63:0] addr, input logic [63:0] rdata,
                            input logic [63:0] exp_addr, input logic [63:0] exp);
    issue(1'b0, sz, uns, addr, 64'h0, 5'd1);
    check({tag, "_addr"}, bus.mem_req_addr, exp_addr);
    step();
    respond(rdata);
    check({tag, "_vld"}, 64'(bus.out_valid), 64'd1);
    check({tag, "_data"}, bus.out_rdata, exp);
    step();
  endtask

  task automatic store_check(input string tag, input logic [1:0] sz, input logic [63:0] addr,
                             input logic [63:0] wd, input logic [7:0] exp_mask,
                             input logic [63:0] exp_wdata, input logic [63:0] exp_addr);
    issue(1'b1, sz, 1'b0, addr, wd, 5'd2);
    check({tag, "_we"}, 64'(bus.mem_req_we), 64'd1);
    check({tag, "_mask"}, 64'(bus.mem_req_wmask), 64'(exp_mask));
    check({tag, "_wdata"}, bus.mem_req_wdata, exp_wdata);
    check({tag, "_addr"}, bus.mem_req_addr, exp_addr);
    step();
    respond(64'hffff_ffff_ffff_ffff);
    check({tag, "_out_vld"}, 64'(bus.out_valid), 64'd1);
    check({tag, "_out_zero"}, bus.out_rdata, 64'h0);
    step();
  endtask

  initial begin
    rst               = 1'b1;
    bus.in_valid      = 1'b0;
    bus.in_store      = 1'b0;
    bus.in_size       = SZ_B;
    bus.in_unsigned   = 1'b0;
    bus.in_addr       = '0;
    bus.in_wdata      = '0;
    bus.in_rd         = '0;
    bus.mem_req_ready = 1'b1;
    bus.mem_rsp_valid = 1'b0;
    bus.mem_rsp_rdata = '0;
    bus.out_ready     = 1'b1;
    step();
    step();
    check("rst_in_ready", 64'(bus.in_ready), 64'd1);
    check("rst_req_vld", 64'(bus.mem_req_valid), 64'd0);
    check("rst_out_vld", 64'(bus.out_valid), 64'd0);
    check("rst_fault", 64'(bus.out_fault), 64'd0);
    check("rst_rdata", bus.out_rdata, 64'h0);
    check("rst_addr", bus.mem_req_addr, 64'h0);
    check("rst_wmask", 64'(bus.mem_req_wmask), 64'h0);
    rst = 1'b0;
    step();

    // lb at byte 3: exact cycle-by-cycle latency
    issue(1'b0, SZ_B, 1'b0, 64'h8000_0003, 64'h0, 5'd5);
    check("lb_n1_req_vld", 64'(bus.mem_req_valid), 64'd1);
    check("lb_n1_addr", bus.mem_req_addr, 64'h8000_0000);
    check("lb_n1_in_ready", 64'(bus.in_ready), 64'd0);
    check("lb_n1_wmask", 64'(bus.mem_req_wmask), 64'h0);
    step();
    check("lb_n2_req_vld", 64'(bus.mem_req_valid), 64'd0);
    check("lb_n2_out_vld", 64'(bus.out_valid), 64'd0);
    respond(64'h0000_0000_8000_0000);
    check("lb_n3_out_vld", 64'(bus.out_valid), 64'd1);
    check("lb_n3_rdata", bus.out_rdata, 64'hffff_ffff_ffff_ff80);
    check("lb_n3_fault", 64'(bus.out_fault), 64'd0);
    check("lb_n3_rd", 64'(bus.out_rd), 64'd5);
    step();
    check("lb_done_out_vld", 64'(bus.out_valid), 64'd0);
    check("lb_done_in_ready", 64'(bus.in_ready), 64'd1);

    load_check("lbu", SZ_B, 1'b1, 64'h8000_0003, 64'h0000_0000_8000_0000, 64'h8000_0000, 64'h80);
    load_check("lh",  SZ_H, 1'b0, 64'h8000_0002, 64'h0000_0000_abcd_0000, 64'h8000_0000, 64'hffff_ffff_ffff_abcd);
    load_check("lhu", SZ_H, 1'b1, 64'h8000_0002, 64'h0000_0000_abcd_0000, 64'h8000_0000, 64'h0000_0000_0000_abcd);
    load_check("lw",  SZ_W, 1'b0, 64'h8000_0004, 64'h8765_4321_0000_0000, 64'h8000_0000, 64'hffff_ffff_8765_4321);
    load_check("lwu", SZ_W, 1'b1, 64'h8000_0004, 64'h8765_4321_0000_0000, 64'h8000_0000, 64'h0000_0000_8765_4321);
    load_check("ld",  SZ_D, 1'b0, 64'h8000_0008, 64'h1122_3344_5566_7788, 64'h8000_0008, 64'h1122_3344_5566_7788);

    store_check("sh", SZ_H, 64'h8000_0006, 64'hdead_beef_0000_1234, 8'hc0, 64'h1234_0000_0000_0000, 64'h8000_0000);
    store_check("sb", SZ_B, 64'h8000_0005, 64'h0000_0000_0000_00ab, 8'h20, 64'h0000_ab00_0000_0000, 64'h8000_0000);
    store_check("sw", SZ_W, 64'h8000_0004, 64'hffff_ffff_cafe_babe, 8'hf0, 64'hcafe_babe_0000_0000, 64'h8000_0000);
    store_check("sd", SZ_D, 64'h8000_0008, 64'h0123_4567_89ab_cdef, 8'hff, 64'h0123_4567_89ab_cdef, 64'h8000_0008);

`ifndef YSYX_22050612_LSU_MISALIGN_SPLIT_EN
    r0 = req_cnt;
    issue(1'b0, SZ_W, 1'b0, 64'h8000_0002, 64'h0, 5'd7);
    check("flt_lw_out_vld", 64'(bus.out_valid), 64'd1);
    check("flt_lw_fault", 64'(bus.out_fault), 64'd1);
    check("flt_lw_req_vld", 64'(bus.mem_req_valid), 64'd0);
    check("flt_lw_rdata", bus.out_rdata, 64'h0);
    check("flt_lw_rd", 64'(bus.out_rd), 64'd7);
    step();
    check("flt_lw_cleared", 64'(bus.out_valid), 64'd0);
    issue(1'b0, SZ_H, 1'b0, 64'h8000_0001, 64'h0, 5'd8);
    check("flt_lh_fault", 64'(bus.out_fault), 64'd1);
    check("flt_lh_req_vld", 64'(bus.mem_req_valid), 64'd0);
    step();
    check("flt_no_mem_req", 64'(req_cnt - r0), 64'd0);
`else
    r0 = req_cnt;
    o0 = out_cnt;
    issue(1'b0, SZ_D, 1'b0, 64'h8000_0004, 64'h0, 5'd9);
    check("split_req1_addr", bus.mem_req_addr, 64'h8000_0000);
    step();
    respond(64'haaaa_bbbb_cccc_dddd);
    check("split_req2_vld", 64'(bus.mem_req_valid), 64'd1);
    check("split_req2_addr", bus.mem_req_addr, 64'h8000_0008);
    check("split_mid_out_vld", 64'(bus.out_valid), 64'd0);
    step();
    respond(64'h1111_2222_3333_4444);
    check("split_out_vld", 64'(bus.out_valid), 64'd1);
    check("split_rdata", bus.out_rdata, 64'h3333_4444_aaaa_bbbb);
    check("split_fault", 64'(bus.out_fault), 64'd0);
    step();
    check("split_req_cnt", 64'(req_cnt - r0), 64'd2);
    check("split_out_cnt", 64'(out_cnt - o0), 64'd1);
`endif

    // Back-pressure on both sides; a stray response while in REQ must be ignored
    r0 = req_cnt;
    o0 = out_cnt;
    bus.mem_req_ready = 1'b0;
    issue(1'b1, SZ_W, 1'b0, 64'h8000_0010, 64'h0000_0000_cafe_babe, 5'd3);
    for (int i = 0; i < 5; i++) begin
      check("bp_req_vld", 64'(bus.mem_req_valid), 64'd1);
      check("bp_req_addr", bus.mem_req_addr, 64'h8000_0010);
      check("bp_req_wmask", 64'(bus.mem_req_wmask), 64'h0f);
      check("bp_req_wdata", bus.mem_req_wdata, 64'h0000_0000_cafe_babe);
      bus.mem_rsp_valid = 1'b1;
      bus.mem_rsp_rdata = 64'hffff_ffff_ffff_ffff;
      step();
    end
    bus.mem_rsp_valid = 1'b0;
    check("bp_still_req", 64'(bus.mem_req_valid), 64'd1);
    bus.mem_req_ready = 1'b1;
    bus.out_ready     = 1'b0;
    step();
    respond(64'h0);
    for (int i = 0; i < 3; i++) begin
      check("bp_out_vld", 64'(bus.out_valid), 64'd1);
      check("bp_out_rd", 64'(bus.out_rd), 64'd3);
      check("bp_out_rdata", bus.out_rdata, 64'h0);
      step();
    end
    bus.out_ready = 1'b1;
    step();
    check("bp_out_cleared", 64'(bus.out_valid), 64'd0);
    check("bp_one_req", 64'(req_cnt - r0), 64'd1);
    check("bp_one_out", 64'(out_cnt - o0), 64'd1);

    // Reset during WAIT, stale response the cycle after
    issue(1'b0, SZ_W, 1'b0, 64'h8000_0020, 64'h0, 5'd4);
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    respond(64'h0000_0000_0000_1234);
    check("abort_out_vld", 64'(bus.out_valid), 64'd0);
    check("abort_in_ready", 64'(bus.in_ready), 64'd1);
    check("abort_req_vld", 64'(bus.mem_req_valid), 64'd0);
    step();
    check("abort_out_vld2", 64'(bus.out_valid), 64'd0);
    load_check("post_abort_lbu", SZ_B, 1'b1, 64'h8000_0021, 64'h0000_0000_0000_5a00, 64'h8000_0020, 64'h5a);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/ysyx_22050612_lsu.md
YSYX_22050612_LSU -- requirements
Module: ysyx_22050612_lsu

Interface
REQ-001 Parameter XLEN, default 64, data/address width; legal values 32 and 64.
REQ-002 Parameter NBYTE, default XLEN/8, number of byte lanes; derived, never overridden.
REQ-003 clk  input  1  single clock; all state updates on the rising edge.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 in_valid  input  1  request present.
REQ-006 in_ready  output  1  LSU accepts a request.
REQ-007 in_store  input  1  1 = store, 0 = load.
REQ-008 in_size  input  2  access size: 0 = byte, 1 = half, 2 = word, 3 = double.
REQ-009 in_unsigned  input  1  zero-extend load result.
REQ-010 in_addr  input  XLEN  byte address.
REQ-011 in_wdata  input  XLEN  store data, right-justified.
REQ-012 in_rd  input  5  destination register tag, returned unchanged.
REQ-013 mem_req_valid / mem_req_ready  output / input  1 each  memory request handshake.
REQ-014 mem_req_we  output  1  write enable.
REQ-015 mem_req_addr  output  XLEN  in_addr with its low log2(NBYTE) bits cleared.
REQ-016 mem_req_wdata  output  XLEN  store data shifted to its byte lanes.
REQ-017 mem_req_wmask  output  NBYTE  store byte-lane enables; all zero for loads.
REQ-018 mem_rsp_valid / mem_rsp_rdata  input  1 / XLEN  response; asserted for loads and stores.
REQ-019 out_valid / out_ready  output / input  1 each  result handshake.
REQ-020 out_rdata  output  XLEN  extended load data; 0 for stores and faults.
REQ-021 out_rd / out_fault  output  5 / 1  tag; access fault flag.

Function
REQ-022 FSM states: IDLE, REQ, WAIT, DONE. in_ready SHALL be 1 only in IDLE.
REQ-023 IDLE: on in_valid, latch all in_* fields and go to REQ; if the access is illegal, set fault and go directly to DONE.
REQ-024 Illegal access: address not aligned to the access size, or in_size = 3 when XLEN = 32.
REQ-025 REQ: mem_req_valid = 1 with stable fields; on mem_req_ready, go to WAIT.
REQ-026 WAIT: on mem_rsp_valid, capture the extended data and go to DONE.
REQ-027 mem_rsp_valid outside WAIT SHALL be ignored.
REQ-028 DONE: out_valid = 1, outputs stable; on out_ready, go to IDLE.
REQ-029 No request SHALL be accepted in the cycle the LSU leaves DONE.
REQ-030 Minimum latency, with mem_req_ready = 1 and mem_rsp_valid one cycle after the request: accept at cycle N, mem_req_valid at N+1, response at N+2, out_valid at N+3.
REQ-031 Fault latency: accept at N, out_valid at N+1; no memory request issued.
REQ-032 Store lane placement: wdata = in_wdata[8<<size-1:0] << (8*addr[low]); wmask = ((1<<(1<<size))-1) << addr[low].
REQ-033 Load extraction: lane selected by addr[low], sign-extended from bit 8<<size-1 unless in_unsigned; size = XLEN passes through.
REQ-034 Back-pressure: mem_req_ready low holds REQ indefinitely; out_ready low holds DONE indefinitely.

Reset
REQ-035 rst → IDLE in the next cycle, from any state, including mid-transaction.
REQ-036 Reset values: in_ready = 1, mem_req_valid = 0, out_valid = 0, out_fault = 0; all data outputs 0.
REQ-037 A memory response belonging to an aborted transaction SHALL be discarded.

Configuration
REQ-038 Macro YSYX_22050612_LSU_MISALIGN_SPLIT_EN.
REQ-039 Defined: a misaligned half/word/double access that crosses a lane boundary becomes two sequential memory transactions (low line, then high line), merged into one result with one out_valid; no fault is raised.
REQ-040 Defined: the extra transaction adds one full REQ/WAIT pair of latency.
REQ-041 Undefined: the behaviour of REQ-023/REQ-024 applies (fault).

Structure
REQ-042 Shared package ysyx_22050612_lsu_pkg holds the FSM state enum, the size encoding constants, and the function computing wmask and lane shift.
REQ-043 One sub-module, ysyx_22050612_lsu_ext, SHALL be used: combinational lane extract plus sign/zero extend.

Verification
REQ-044 XLEN = 64, lb addr 0x8000_0003, rdata 0x0000_0000_8000_0000 → out_rdata 0xFFFF_FFFF_FFFF_FF80, out_fault = 0.
REQ-045 sh addr 0x8000_0006, wdata 0x1234 → mem_req_wmask 0xC0, mem_req_wdata 0x1234_0000_0000_0000, mem_req_addr 0x8000_0000.
REQ-046 lw addr 0x8000_0002, macro undefined → out_valid at N+1 with out_fault = 1, mem_req_valid never asserted.
REQ-047 mem_req_ready held low 5 cycles, then out_ready held low 3 cycles → fields stable throughout; exactly one request and one result observed.
REQ-048 rst asserted during WAIT, stale mem_rsp_valid arrives the next cycle → IDLE, out_valid remains 0.
REQ-049 Macro defined, ld addr 0x8000_0004 → two requests (0x8000_0000, then 0x8000_0008), merged little-endian result, one out_valid.
